// File: rtl/pmf_pkg.sv
// Shared encodings for the pmf ALU unit: operation codes and FSM states.
package pmf_pkg;

  localparam int unsigned OP_W    = 2;
  localparam int unsigned STATE_W = 2;

  localparam logic [OP_W-1:0] ALU_ADD = 2'd0;
  localparam logic [OP_W-1:0] ALU_SUB = 2'd1;
  localparam logic [OP_W-1:0] ALU_AND = 2'd2;
  localparam logic [OP_W-1:0] ALU_OR  = 2'd3;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_INV  = 2'd1;
  localparam logic [STATE_W-1:0] ST_REQ  = 2'd2;

endpackage

// File: rtl/pmf_fifo.sv
// Pending-op queue: power-of-two FIFO with a registered occupancy count.
// Reads are taken straight from the head entry, so a push into an empty queue is only visible on the next edge.
module pmf_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     nRST,
  input  logic                     push,
  input  logic [DW-1:0]            din,
  input  logic                     pop,
  output logic [DW-1:0]            dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage needs no reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (do_pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      case ({do_push, do_pop})
        2'b10:   count <= CNT_W'(count + 1'b1);
        2'b01:   count <= CNT_W'(count - 1'b1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pmf_alu_unit.sv
// Reservation-station fed ALU: queues issued ops, evaluates one at a time and
// holds each result on the common data bus until the arbiter grants it.
module pmf_alu_unit
  import pmf_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LABEL_W = 4,
  parameter int unsigned DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   nRST,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OP_W-1:0]        in_op,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  input  logic [LABEL_W-1:0]     in_label,
  output logic                   cdb_req,
  input  logic                   cdb_grant,
  output logic [WIDTH-1:0]       cdb_result,
  output logic [LABEL_W-1:0]     cdb_label,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned DW = OP_W + 2 * WIDTH + LABEL_W;

  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [LABEL_W-1:0] label;
  } entry_t;

  entry_t               push_entry;
  entry_t               head;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [STATE_W-1:0]   state_q;
  logic [STATE_W-1:0]   state_d;
  logic [OP_W-1:0]      op_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [LABEL_W-1:0]   label_q;

  assign push_entry = '{op: in_op, a: in_a, b: in_b, label: in_label};
  assign in_ready   = !full;
  assign push       = in_valid && in_ready;

  pmf_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .nRST  (nRST),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Next-state and pop decision; a grant with work pending reloads immediately.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = (head.op == ALU_SUB) ? ST_INV : ST_REQ;
        end
      end
      ST_INV: state_d = ST_REQ;
      ST_REQ: begin
        if (cdb_grant) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = (head.op == ALU_SUB) ? ST_INV : ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Operand latches; INV replaces b with its two's complement so SUB reuses the adder.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      label_q <= '0;
    end else if (pop) begin
      op_q    <= head.op;
      a_q     <= head.a;
      b_q     <= head.b;
      label_q <= head.label;
    end else if (state_q == ST_INV) begin
      b_q <= WIDTH'(~b_q + 1'b1);
    end
  end

  always_comb begin
    cdb_result = '0;
    case (op_q)
      ALU_ADD, ALU_SUB: cdb_result = WIDTH'(a_q + b_q);
      ALU_AND:          cdb_result = a_q & b_q;
      ALU_OR:           cdb_result = a_q | b_q;
      default:          cdb_result = '0;
    endcase
  end

  assign cdb_label = label_q;
  assign cdb_req   = (state_q == ST_REQ);
  assign busy      = !empty || (state_q != ST_IDLE);

endmodule
